// File: rtl/fpdiv_arbiter_if.sv
// fpdiv_arbiter_if: requester and divider signals shared by the arbiter and its environment
interface fpdiv_arbiter_if #(parameter int NREQ = 2);
   logic [NREQ-1:0]    req, ack;
   logic [32*NREQ-1:0] x_in, y_in;
   logic [31:0]        z_out, div_x, div_y, div_z;
   logic               busy, div_run, div_stall;
   modport slave (input req, x_in, y_in, div_stall, div_z, output ack, z_out, busy, div_run, div_x, div_y);
   modport master (output req, x_in, y_in, div_stall, div_z, input ack, z_out, busy, div_run, div_x, div_y);
endinterface

// File: rtl/fpdiv_arbiter.sv
// fpdiv_arbiter: round-robin sharing of one iterative FP divider among NREQ requesters
// Optional macro FPDIV_FASTPATH_EN answers zero-exponent operands without running the divider.
module fpdiv_arbiter #(
   parameter int NREQ       = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic           clk,
   input  logic           rst,
   fpdiv_arbiter_if.slave bus
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(GAP_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, GRANT, RUN, DONE, GAP} state_t;
   state_t        state_q, state_d;
   logic [IW-1:0] rr_q, rr_d, g_q, g_d, win;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   x_q, x_d, y_q, y_d, z_q, z_d, wx, wy, fz;
   logic          run_q, run_d, fast_q, fast_d, found, special;
   always_comb begin
      win   = rr_q;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && bus.req[IW'((int'(rr_q) + k) % NREQ)]) begin
            win   = IW'((int'(rr_q) + k) % NREQ);
            found = 1'b1;
         end
      end
      wx = bus.x_in[32*win +: 32];
      wy = bus.y_in[32*win +: 32];
      fz = (wx[30:23] == 8'h00) ? 32'h0 : {wx[31] ^ wy[31], 8'hFF, 23'b0};
`ifdef FPDIV_FASTPATH_EN
      special = (wx[30:23] == 8'h00) || (wy[30:23] == 8'h00);
`else
      special = 1'b0;
`endif
   end
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      g_d     = g_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      run_d   = run_q;
      fast_d  = fast_q;
      case (state_q)
         IDLE: if (found) begin
            x_d     = wx;
            y_d     = wy;
            rr_d    = win;
            g_d     = win;
            fast_d  = special;
            z_d     = special ? fz : z_q;
            state_d = special ? DONE : GRANT;
         end
         GRANT: begin
            run_d   = 1'b1;
            state_d = RUN;
         end
         // stall low marks the last step; holding run any longer overruns the divider
         RUN: if (!bus.div_stall) begin
            z_d     = bus.div_z;
            run_d   = 1'b0;
            state_d = DONE;
         end
         DONE: begin
            cnt_d   = CW'(GAP_CYCLES);
            state_d = fast_q ? IDLE : GAP;
         end
         GAP: begin
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_d == '0) ? IDLE : GAP;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= IW'(NREQ - 1);
         g_q     <= '0;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         run_q   <= 1'b0;
         fast_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         g_q     <= g_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         run_q   <= run_d;
         fast_q  <= fast_d;
      end
   end
   assign bus.ack     = (state_q == DONE) ? (NREQ'(1) << g_q) : '0;
   assign bus.busy    = (state_q != IDLE);
   assign bus.div_run = run_q;
   assign bus.div_x   = x_q;
   assign bus.div_y   = y_q;
   assign bus.z_out   = z_q;
endmodule
